im_loader: RTL and testbench
============================

# im_loader

Program loader for the instruction memory: the write-side counterpart to the read-only instruction ROM. It accepts a byte stream, assembles big-endian 32-bit words (first byte becomes bits 31:24, matching hex-file text order), and writes them sequentially into the instruction memory write port starting at the program base address. It holds the CPU while loading and reports completion or error.

## Interface
- MEM_SIZE, 256, instruction memory depth in words
- BASE_ADDR, 1, word address of the first program word
- LIMIT_ADDR, MEM_SIZE-33 (223), last writable word address; the top 32 words are reserved
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a load; sampled only in IDLE, DONE and ERR
- in_valid  in  1  byte available
- in_data  in  8  byte payload
- in_last  in  1  qualifies the final byte of the stream
- in_ready  out  1  loader accepts a byte this cycle
- we  out  1  instruction memory write strobe, one-cycle pulse
- waddr  out  32  word address; upper bits are zero
- wdata  out  32  assembled word
- cpu_hold  out  1  keep the CPU stalled and in reset
- done  out  1  load completed successfully; level
- err  out  1  load aborted; level
- word_count  out  8  words written in the current or most recent load

## Operation
- States:
  - IDLE
    - in_ready=0, cpu_hold=0.
    - start -> RECV; clear addr to BASE_ADDR, byte_cnt, word_count, and the shift register.
  - RECV
    - in_ready=1.
    - Handshake (in_valid & in_ready): shift_reg <= {shift_reg[23:0], in_data}; byte_cnt++.
    - Handshake with byte_cnt==3 -> WRITE, latching last_q=in_last.
    - Handshake with in_last and byte_cnt!=3 (partial word) -> ERR; nothing is written.
  - WRITE
    - in_ready=0; we=1, waddr=addr, wdata=shift_reg; byte_cnt<=0.
    - Next state:
      - last_q -> DONE.
      - !last_q and addr==LIMIT_ADDR -> ERR (overflow).
      - Otherwise -> RECV with addr++.
    - word_count++ on every write.
  - DONE
    - done=1, cpu_hold=0.
    - start -> RECV with full re-initialisation.
  - ERR
    - err=1, cpu_hold=1.
    - start -> RECV with full re-initialisation.
- cpu_hold=1 in RECV and WRITE.
- Data written before an error remains in memory; it is not rolled back.
- start in RECV or WRITE is ignored.
- in_last is ignored unless a handshake occurs.
- in_data is don't-care when in_valid=0.
- word_count saturates at 255. It cannot exceed 223 given LIMIT_ADDR.

## Timing
- Reset values (asynchronous):
  - State IDLE.
  - in_ready, we, cpu_hold, done, err = 0.
  - waddr, wdata = 0.
  - word_count = 0.
  - byte_cnt, addr, and the shift register are cleared.
- Reset mid-load discards the partial word and any pending write. we never asserts after rst_n falls.
- we asserts in the cycle after the 4th-byte handshake, for exactly one cycle.
- Minimum of 5 cycles per word: 4 byte handshakes plus 1 write cycle.
- done or err asserts in the cycle after the final write or after the error-causing handshake.
- in_ready is registered-state-derived. It is not combinationally dependent on in_valid.
- Address arithmetic: addr is 8-bit internal, zero-extended onto waddr. It never wraps because the LIMIT_ADDR check precedes the increment.

## Configuration
- IM_LOADER_CHECKSUM_EN defined:
  - The final word of the stream (the one completed by in_last) is a checksum and is not written; we stays 0 in that WRITE slot.
  - The running sum of all written words, mod 2^32, is compared with it.
  - Match -> DONE; mismatch -> ERR.
  - word_count excludes the checksum word.
  - A stream of only a checksum word compares against 0.
- Not defined: every complete word, including the last, is written. No checksum logic is synthesized.

## Test plan
- Reset then start; stream 8 bytes 20,08,00,05,00,00,00,0C with in_last on the 8th byte, in_valid held high:
  - 0x20080005 written at addr 1 and 0x0000000C at addr 2, each as a single we pulse.
  - done=1, word_count=2, cpu_hold drops with done.
- Same stream with in_valid gapped every other cycle -> identical writes; we spacing grows; no duplicate or missing bytes.
- Stream 6 bytes with in_last on byte 6 -> one write at addr 1; err=1, cpu_hold=1, word_count=1.
- Stream 224 words without in_last:
  - Writes to addrs 1..223.
  - After the write at 223, err=1; the 224th word is never written.
- Pull rst_n low after 2 bytes of the second word -> all outputs return to reset values immediately. A new start loads cleanly at addr 1.
- IM_LOADER_CHECKSUM_EN defined:
  - Words 0x00000001, 0x00000002, checksum 0x00000003 -> two writes, done=1.
  - Checksum 0x00000004 -> two writes, err=1.

Source files
------------

// File: rtl/im_loader_if.sv
// im_loader_if: byte-stream input and instruction-memory write port of the program loader.
//   in_valid/in_data/in_last/in_ready : byte stream handshake (source -> loader)
//   we/waddr/wdata                    : instruction memory write port (loader -> memory)
// modport master: the environment side (stream source and memory sink).
// modport slave : the loader itself.
interface im_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, we, waddr, wdata
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, we, waddr, wdata
    );
endinterface

// File: rtl/im_loader.sv
// im_loader: program loader for the instruction memory.
// Assembles a byte stream into big-endian 32-bit words (first byte -> bits 31:24) and writes
// them sequentially from BASE_ADDR. Holds the CPU while loading and reports done/err as levels.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   start       : begin a load; honoured only in idle, done and error states
//   bus (slave) : byte stream in (in_valid/in_data/in_last/in_ready), memory write out
//                 (we/waddr/wdata)
//   cpu_hold    : keep the CPU stalled while loading or after an error
//   done, err   : load completed / load aborted
//   word_count  : words written in the current or most recent load (saturating)
// Optional feature: define IM_LOADER_CHECKSUM_EN to treat the final word as a checksum of all
// written words (mod 2^32); it is compared instead of written.
module im_loader #(
    parameter int unsigned MEM_SIZE   = 256,
    parameter int unsigned BASE_ADDR  = 1,
    parameter int unsigned LIMIT_ADDR = MEM_SIZE - 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    im_loader_if.slave  bus,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [7:0]  word_count
);

    typedef enum logic [2:0] {StIdle, StRecv, StWrite, StDone, StErr} state_e;

    localparam logic [7:0] BaseAddr  = 8'(BASE_ADDR);
    localparam logic [7:0] LimitAddr = 8'(LIMIT_ADDR);

    state_e      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] shift_q, shift_d;
    logic        last_q, last_d;
    logic [7:0]  word_count_q, word_count_d;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            last_q       <= 1'b0;
            word_count_q <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            last_q       <= last_d;
            word_count_q <= word_count_d;
`ifdef IM_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        last_d       = last_q;
        word_count_d = word_count_q;
`ifdef IM_LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        bus.in_ready = 1'b0;
        bus.we       = 1'b0;
        bus.waddr    = '0;
        bus.wdata    = '0;
        cpu_hold     = 1'b0;
        done         = 1'b0;
        err          = 1'b0;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                done     = (state_q == StDone);
                err      = (state_q == StErr);
                cpu_hold = (state_q == StErr);
                if (start) begin
                    state_d      = StRecv;
                    addr_d       = BaseAddr;
                    byte_cnt_d   = '0;
                    shift_d      = '0;
                    last_d       = 1'b0;
                    word_count_d = '0;
`ifdef IM_LOADER_CHECKSUM_EN
                    sum_d        = '0;
`endif
                end
            end
            StRecv: begin
                cpu_hold     = 1'b1;
                bus.in_ready = 1'b1;
                // in_ready is unconditionally high here, so in_valid alone is the handshake
                if (bus.in_valid) begin
                    shift_d    = {shift_q[23:0], bus.in_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StWrite;
                        last_d  = bus.in_last;
                    end else if (bus.in_last) begin
                        state_d = StErr;  // partial word: nothing written
                    end
                end
            end
            StWrite: begin
                cpu_hold   = 1'b1;
                byte_cnt_d = '0;
`ifdef IM_LOADER_CHECKSUM_EN
                if (last_q) begin
                    // Checksum slot: compare, never write, not counted
                    state_d = (sum_q == shift_q) ? StDone : StErr;
                end else begin
                    bus.we       = 1'b1;
                    bus.waddr    = {24'b0, addr_q};
                    bus.wdata    = shift_q;
                    sum_d        = sum_q + shift_q;
                    word_count_d = (word_count_q == 8'hFF) ? word_count_q : word_count_q + 8'd1;
                    if (addr_q == LimitAddr) begin
                        state_d = StErr;
                    end else begin
                        state_d = StRecv;
                        addr_d  = addr_q + 8'd1;
                    end
                end
`else
                bus.we       = 1'b1;
                bus.waddr    = {24'b0, addr_q};
                bus.wdata    = shift_q;
                word_count_d = (word_count_q == 8'hFF) ? word_count_q : word_count_q + 8'd1;
                if (last_q) begin
                    state_d = StDone;
                end else if (addr_q == LimitAddr) begin
                    state_d = StErr;  // limit check precedes increment, so addr never wraps
                end else begin
                    state_d = StRecv;
                    addr_d  = addr_q + 8'd1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    assign word_count = word_count_q;

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed self-checking bench for im_loader.
module tb_im_loader;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic cpu_hold, done, err;
    logic [7:0] word_count;

    im_loader_if bus ();

    im_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus.slave),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Write log, captured mid-cycle so a one-cycle we pulse yields exactly one entry
    int          cyc = 0;
    int          log_n = 0;
    int          we_in_reset = 0;
    logic [31:0] log_addr [512];
    logic [31:0] log_data [512];
    int          log_cyc  [512];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            if (log_n < 512) begin
                log_addr[log_n] <= bus.waddr;
                log_data[log_n] <= bus.wdata;
                log_cyc[log_n]  <= cyc;
            end
            log_n <= log_n + 1;
        end
        if (!rst_n && bus.we !== 1'b0) we_in_reset <= we_in_reset + 1;
    end

    // All tasks start and end #1 after a rising edge.
    task automatic send_byte(input logic [7:0] d, input logic last);
        bit got = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                got = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'h00;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout: byte %h in_ready=%b required 1", d, bus.in_ready);
        end
    endtask

    // gap inserts one idle cycle after every byte that is not flagged last
    task automatic send_word(input logic [31:0] w, input logic last, input logic gap);
        logic [31:0] v;
        v = w;
        for (int b = 0; b < 4; b++) begin
            send_byte(v[31:24], last && (b == 3));
            v = v << 8;
            if (gap && !(last && (b == 3))) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", bus.we); end
        n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_hold: got %b expected 0", cpu_hold); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (bus.waddr !== 32'h0) begin n_fail++; $display("FAIL reset_waddr: got %h expected 0", bus.waddr); end
        n_checks++; if (bus.wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", bus.wdata); end
        n_checks++; if (word_count !== 8'd0) begin n_fail++; $display("FAIL reset_word_count: got %0d expected 0", word_count); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL idle_cpu_hold: got %b expected 0", cpu_hold); end
    endtask

    task automatic test_two_words(input logic gap);
        int base;
        int spacing;
        base = log_n;
        spacing = gap ? 8 : 5;
        do_start();
        n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL recv_cpu_hold: got %b expected 1", cpu_hold); end
        send_word(32'h20080005, 1'b0, gap);
        send_word(32'h0000000C, 1'b1, gap);
        n_checks++; if (bus.we !== 1'b1 || bus.waddr !== 32'd2) begin n_fail++; $display("FAIL last_write_slot: we=%b waddr=%h expected we=1 waddr=2", bus.we, bus.waddr); end
        @(posedge clk);
        #1;
        n_checks++; if (done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL two_done: done=%b err=%b expected 1/0", done, err); end
        n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL two_cpu_hold: got %b expected 0", cpu_hold); end
        n_checks++; if (word_count !== 8'd2) begin n_fail++; $display("FAIL two_word_count: got %0d expected 2", word_count); end
        n_checks++; if (log_n - base !== 2) begin n_fail++; $display("FAIL two_write_count: got %0d expected 2", log_n - base); end
        n_checks++; if (log_addr[base] !== 32'd1 || log_data[base] !== 32'h20080005) begin n_fail++; $display("FAIL two_write0: got %h@%h expected 20080005@1", log_data[base], log_addr[base]); end
        n_checks++; if (log_addr[base+1] !== 32'd2 || log_data[base+1] !== 32'h0000000C) begin n_fail++; $display("FAIL two_write1: got %h@%h expected 0000000c@2", log_data[base+1], log_addr[base+1]); end
        n_checks++; if (log_cyc[base+1] - log_cyc[base] !== spacing) begin n_fail++; $display("FAIL two_we_spacing: got %0d expected %0d", log_cyc[base+1] - log_cyc[base], spacing); end
    endtask

    task automatic test_partial();
        int base;
        base = log_n;
        do_start();
        send_word(32'h11223344, 1'b0, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b1);
        n_checks++; if (err !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL partial_err: err=%b done=%b expected 1/0", err, done); end
        n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL partial_cpu_hold: got %b expected 1", cpu_hold); end
        n_checks++; if (word_count !== 8'd1) begin n_fail++; $display("FAIL partial_word_count: got %0d expected 1", word_count); end
        n_checks++; if (log_n - base !== 1 || log_addr[base] !== 32'd1 || log_data[base] !== 32'h11223344) begin n_fail++; $display("FAIL partial_writes: n=%0d first=%h@%h expected 1 write 11223344@1", log_n - base, log_data[base], log_addr[base]); end
    endtask

    task automatic test_overflow();
        int base;
        int bad;
        logic [7:0] kb;
        base = log_n;
        bad = 0;
        do_start();
        for (int k = 0; k < 223; k++) begin
            kb = 8'(k);
            send_word({kb, 8'hA5, 8'h5A, ~kb}, 1'b0, 1'b0);
        end
        @(posedge clk);
        #1;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL overflow_err: got %b expected 1", err); end
        n_checks++; if (word_count !== 8'd223) begin n_fail++; $display("FAIL overflow_word_count: got %0d expected 223", word_count); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL overflow_in_ready: got %b expected 0", bus.in_ready); end
        for (int k = 0; k < 223; k++) begin
            kb = 8'(k);
            if (log_addr[base+k] !== 32'(k + 1) || log_data[base+k] !== {kb, 8'hA5, 8'h5A, ~kb}) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL overflow_contents: %0d bad entries expected 0", bad); end
        // Offer a 224th word; it must not be taken
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        repeat (6) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n_checks++; if (log_n - base !== 223) begin n_fail++; $display("FAIL overflow_write_count: got %0d expected 223", log_n - base); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL overflow_err_held: got %b expected 1", err); end
    endtask

    task automatic test_reset_midload();
        int base;
        do_start();
        send_word(32'hCAFEF00D, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midload_in_ready: got %b expected 1", bus.in_ready); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0 || cpu_hold !== 1'b0 || bus.we !== 1'b0) begin n_fail++; $display("FAIL midload_reset_ctrl: in_ready=%b cpu_hold=%b we=%b expected 0/0/0", bus.in_ready, cpu_hold, bus.we); end
        n_checks++; if (word_count !== 8'd0 || done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL midload_reset_status: wc=%0d done=%b err=%b expected 0/0/0", word_count, done, err); end
        n_checks++; if (bus.waddr !== 32'h0 || bus.wdata !== 32'h0) begin n_fail++; $display("FAIL midload_reset_bus: waddr=%h wdata=%h expected 0/0", bus.waddr, bus.wdata); end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_checks++; if (we_in_reset !== 0) begin n_fail++; $display("FAIL we_during_reset: got %0d pulses expected 0", we_in_reset); end
        @(posedge clk);
        #1;
        base = log_n;
        do_start();
`ifdef IM_LOADER_CHECKSUM_EN
        send_word(32'hDEADBEEF, 1'b0, 1'b0);
        send_word(32'hDEADBEEF, 1'b1, 1'b0);
`else
        send_word(32'hDEADBEEF, 1'b1, 1'b0);
`endif
        @(posedge clk);
        #1;
        n_checks++; if (done !== 1'b1 || word_count !== 8'd1) begin n_fail++; $display("FAIL reload_done: done=%b wc=%0d expected 1/1", done, word_count); end
        n_checks++; if (log_n - base !== 1 || log_addr[base] !== 32'd1 || log_data[base] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL reload_write: n=%0d %h@%h expected 1 write deadbeef@1", log_n - base, log_data[base], log_addr[base]); end
    endtask

`ifdef IM_LOADER_CHECKSUM_EN
    task automatic test_checksum(input logic [31:0] csum, input logic expect_ok);
        int base;
        base = log_n;
        do_start();
        send_word(32'h00000001, 1'b0, 1'b0);
        send_word(32'h00000002, 1'b0, 1'b0);
        send_word(csum, 1'b1, 1'b0);
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL csum_slot_we: got %b expected 0", bus.we); end
        @(posedge clk);
        #1;
        n_checks++; if (done !== expect_ok || err !== !expect_ok) begin n_fail++; $display("FAIL csum_result: done=%b err=%b expected %b/%b", done, err, expect_ok, !expect_ok); end
        n_checks++; if (word_count !== 8'd2 || log_n - base !== 2) begin n_fail++; $display("FAIL csum_writes: wc=%0d n=%0d expected 2/2", word_count, log_n - base); end
    endtask
`endif

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        test_reset();
`ifdef IM_LOADER_CHECKSUM_EN
        test_checksum(32'h00000003, 1'b1);
        test_checksum(32'h00000004, 1'b0);
`else
        test_two_words(1'b0);
        test_two_words(1'b1);
`endif
        test_partial();
        test_overflow();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
